// File: rtl/fetch_unit_pkg.sv
// Shared fetch-stage definitions: reset constants, NOP encoding and fetch FSM states.
package fetch_unit_pkg;

    localparam logic [31:0] INSTR_NOP        = 32'h0000_0013;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef enum logic [0:0] {
        IF_ST_FETCH = 1'b0,
        IF_ST_DRAIN = 1'b1
    } if_state_e;

    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry {pc, instr} holding buffer that absorbs a response while decode is stalled.
module fetch_skid_buf
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        unload,
    input  logic        flush,
    input  logic [31:0] in_pc,
    input  logic [31:0] in_instr,
    output logic        valid,
    output logic [31:0] out_pc,
    output logic [31:0] out_instr
);

    logic        valid_d, valid_q;
    logic [31:0] pc_d, pc_q;
    logic [31:0] instr_d, instr_q;

    // Next-entry selection; flush beats load beats unload.
    always_comb begin
        valid_d = valid_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        if (flush) begin
            valid_d = 1'b0;
        end else if (load) begin
            valid_d = 1'b1;
            pc_d    = in_pc;
            instr_d = in_instr;
        end else if (unload) begin
            valid_d = 1'b0;
        end else begin
            valid_d = valid_q;
        end
    end

    // Entry registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            pc_q    <= RESET_PC;
            instr_q <= INSTR_NOP;
        end else begin
            valid_q <= valid_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
        end
    end

    assign valid     = valid_q;
    assign out_pc    = pc_q;
    assign out_instr = instr_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, single-outstanding imem handshake, skid buffer and redirect drain.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        if_valid,
    output logic [31:0] if_pc,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc4
);

    if_state_e   state_d, state_q;
    logic [31:0] pc_d, pc_q;
    logic [31:0] hold_d, hold_q;
    logic        out_valid_d, out_valid_q;
    logic [31:0] out_pc_d, out_pc_q;
    logic [31:0] out_instr_d, out_instr_q;
    logic [31:0] out_pc4_d, out_pc4_q;

    logic        req_int_s;
    logic        skid_valid_s;
    logic        skid_load_s;
    logic        skid_unload_s;
    logic        skid_flush_s;
    logic [31:0] skid_pc_s;
    logic [31:0] skid_instr_s;

    // The request depends only on registered state, never on imem_ready.
    assign req_int_s = (state_q == IF_ST_DRAIN) || !skid_valid_s;
    assign imem_req  = req_int_s && !rst;
    assign imem_addr = (state_q == IF_ST_DRAIN) ? hold_q : pc_q;

    fetch_skid_buf #(
        .RESET_PC (RESET_PC)
    ) u_skid (
        .clk       (clk),
        .rst       (rst),
        .load      (skid_load_s),
        .unload    (skid_unload_s),
        .flush     (skid_flush_s),
        .in_pc     (pc_q),
        .in_instr  (imem_rdata),
        .valid     (skid_valid_s),
        .out_pc    (skid_pc_s),
        .out_instr (skid_instr_s)
    );

    // Next-state, PC and output-register selection; redirect overrides everything.
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        hold_d        = hold_q;
        out_valid_d   = out_valid_q;
        out_pc_d      = out_pc_q;
        out_instr_d   = out_instr_q;
        out_pc4_d     = out_pc4_q;
        skid_load_s   = 1'b0;
        skid_unload_s = 1'b0;
        skid_flush_s  = 1'b0;
        if (redirect_valid) begin
            out_valid_d  = 1'b0;
            skid_flush_s = 1'b1;
            pc_d         = align_word(redirect_pc);
            if (state_q == IF_ST_DRAIN) begin
                state_d = imem_ready ? IF_ST_FETCH : IF_ST_DRAIN;
            end else if (req_int_s && !imem_ready) begin
                // Keep presenting the old address until memory takes it.
                state_d = IF_ST_DRAIN;
                hold_d  = pc_q;
            end else begin
                state_d = IF_ST_FETCH;
            end
        end else begin
            case (state_q)
                IF_ST_FETCH: begin
                    if (req_int_s && imem_ready) begin
                        pc_d = pc_q + 32'd4;
                        if (!out_valid_q || !stall) begin
                            out_valid_d = 1'b1;
                            out_pc_d    = pc_q;
                            out_instr_d = imem_rdata;
                            out_pc4_d   = pc_q + 32'd4;
                        end else begin
                            skid_load_s = 1'b1;
                        end
                    end else if (out_valid_q && !stall) begin
                        if (skid_valid_s) begin
                            out_pc_d      = skid_pc_s;
                            out_instr_d   = skid_instr_s;
                            out_pc4_d     = skid_pc_s + 32'd4;
                            skid_unload_s = 1'b1;
                        end else begin
                            out_valid_d = 1'b0;
                        end
                    end else begin
                        out_valid_d = out_valid_q;
                    end
                end
                IF_ST_DRAIN: begin
                    state_d = imem_ready ? IF_ST_FETCH : IF_ST_DRAIN;
                end
                default: begin
                    state_d = IF_ST_FETCH;
                end
            endcase
        end
    end

    // State, PC and decode-facing output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IF_ST_FETCH;
            pc_q        <= RESET_PC;
            hold_q      <= RESET_PC;
            out_valid_q <= 1'b0;
            out_pc_q    <= RESET_PC;
            out_instr_q <= INSTR_NOP;
            out_pc4_q   <= RESET_PC + 32'd4;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            hold_q      <= hold_d;
            out_valid_q <= out_valid_d;
            out_pc_q    <= out_pc_d;
            out_instr_q <= out_instr_d;
            out_pc4_q   <= out_pc4_d;
        end
    end

    assign if_valid = out_valid_q;
    assign if_pc    = out_pc_q;
    assign if_instr = out_instr_q;
    assign if_pc4   = out_pc4_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit with a combinational addr^A5A5_0000 memory.
module tb_fetch_unit;

    logic        clk;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
    logic [31:0] if_pc4;

    int checks = 0;
    int errors = 0;
    logic seen_40 = 1'b0;

    fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ready     (imem_ready),
        .imem_rdata     (imem_rdata),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .if_valid       (if_valid),
        .if_pc          (if_pc),
        .if_instr       (if_instr),
        .if_pc4         (if_pc4)
    );

    assign imem_rdata = imem_addr ^ 32'hA5A5_0000;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Flags any delivery of the word at 0x40, which must be dropped by the redirect drain.
    always @(negedge clk) begin
        if (if_valid && if_pc == 32'h0000_0040) seen_40 <= 1'b1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic [31:0] pc);
        chk({tag, ".valid"}, {31'd0, if_valid}, 32'd1);
        chk({tag, ".pc"},    if_pc, pc);
        chk({tag, ".instr"}, if_instr, pc ^ 32'hA5A5_0000);
        chk({tag, ".pc4"},   if_pc4, pc + 32'd4);
    endtask

    task automatic chk_req(input string tag, input logic req, input logic [31:0] addr);
        chk({tag, ".req"}, {31'd0, imem_req}, {31'd0, req});
        if (req) chk({tag, ".addr"}, imem_addr, addr);
    endtask

    initial begin
        rst            = 1'b1;
        imem_ready     = 1'b1;
        stall          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        #1;
        chk("rst.req",   {31'd0, imem_req}, 32'd0);
        chk("rst.addr",  imem_addr, 32'h0000_0000);
        chk("rst.valid", {31'd0, if_valid}, 32'd0);
        chk("rst.pc",    if_pc, 32'h0000_0000);
        chk("rst.instr", if_instr, 32'h0000_0013);
        chk("rst.pc4",   if_pc4, 32'h0000_0004);

        step();
        rst = 1'b0;
        #1;
        chk_req("rel", 1'b1, 32'h0);
        step();
        chk_out("first", 32'h0);
        chk_req("first", 1'b1, 32'h4);
        step();
        chk_out("seq4", 32'h4);
        step();
        chk_out("seq8", 32'h8);
        chk_req("seq8", 1'b1, 32'hC);

        // Stall three cycles with 0x8 on the output; 0xC goes to the skid buffer.
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk_out("stall", 32'h8);
            chk_req("stall", 1'b0, 32'h0);
        end
        stall = 1'b0;
        step();
        chk_out("unskid", 32'hC);
        chk_req("unskid", 1'b1, 32'h10);
        step();
        chk_out("after_skid", 32'h10);
        for (int i = 0; i < 3; i++) step();
        chk_out("pre_wait", 32'h1C);
        chk_req("pre_wait", 1'b1, 32'h20);

        // Memory not ready for four cycles at 0x20.
        imem_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("wait.valid", {31'd0, if_valid}, 32'd0);
            chk_req("wait", 1'b1, 32'h20);
        end
        imem_ready = 1'b1;
        step();
        chk_out("wait_done", 32'h20);
        for (int i = 0; i < 7; i++) step();
        chk_out("pre_redir", 32'h3C);
        chk_req("pre_redir", 1'b1, 32'h40);

        // Redirect to 0x103 while 0x40 is waiting.
        imem_ready = 1'b0;
        step();
        chk("hold40.valid", {31'd0, if_valid}, 32'd0);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0103;
        step();
        redirect_valid = 1'b0;
        chk("drain.valid", {31'd0, if_valid}, 32'd0);
        chk_req("drain", 1'b1, 32'h40);
        step();
        chk_req("drain2", 1'b1, 32'h40);
        imem_ready = 1'b1;
        step();
        chk("drained.valid", {31'd0, if_valid}, 32'd0);
        chk_req("drained", 1'b1, 32'h100);
        step();
        chk_out("target", 32'h100);

        // Redirect with the skid buffer full.
        stall = 1'b1;
        step();
        chk_out("skidfull", 32'h100);
        chk_req("skidfull", 1'b0, 32'h0);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0200;
        step();
        redirect_valid = 1'b0;
        stall          = 1'b0;
        chk("flush.valid", {31'd0, if_valid}, 32'd0);
        chk_req("flush", 1'b1, 32'h200);
        step();
        chk_out("flush_tgt", 32'h200);

        // Redirect in the same cycle as an accepted response (0x204 dropped).
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0300;
        step();
        redirect_valid = 1'b0;
        chk("rdy_redir.valid", {31'd0, if_valid}, 32'd0);
        chk_req("rdy_redir", 1'b1, 32'h300);
        step();
        chk_out("rdy_redir_tgt", 32'h300);

        // PC wrap at the top of the address space.
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFC;
        step();
        redirect_valid = 1'b0;
        chk_req("wrap", 1'b1, 32'hFFFF_FFFC);
        step();
        chk_out("wrap_top", 32'hFFFF_FFFC);
        chk("wrap.pc4", if_pc4, 32'h0000_0000);
        chk_req("wrap_next", 1'b1, 32'h0);
        step();
        chk_out("wrap_zero", 32'h0);

        // Asynchronous reset mid-stream.
        #2;
        rst = 1'b1;
        #1;
        chk("arst.valid", {31'd0, if_valid}, 32'd0);
        chk("arst.req",   {31'd0, imem_req}, 32'd0);
        chk("arst.pc",    if_pc, 32'h0000_0000);
        chk("arst.instr", if_instr, 32'h0000_0013);
        chk("arst.pc4",   if_pc4, 32'h0000_0004);
        chk("arst.addr",  imem_addr, 32'h0000_0000);
        chk("no_0x40", {31'd0, seen_40}, 32'd0);

        step();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
